fp_muldiv_ctrl: RTL and testbench
=================================

// Module: fp_muldiv_ctrl
// PURPOSE
//  Sequencer for the FP multiply/divide datapath. Accepts one operation per request via a
//  valid/ready handshake. Drives the exponent logic (enable, add/sub select), then the
//  mantissa unit (load, iterative steps), then the normalise and round stages.
//  Returns completion via a valid/ready response. Only one operation is in flight at a time.
// PARAMETERS
//  MUL_LAT   2   mantissa-multiply step cycles (>=1)
//  DIV_ITER  26  mantissa-divide iterations; MANT_W+2, restoring divider (>=1)
//  CNT_W     $clog2(max(MUL_LAT,DIV_ITER)+1)  iteration counter width (derived; do not override)
// PORTS
//  clk          in   1      clock, all logic on rising edge
//  arst         in   1      reset, synchronous, active-high
//  req_valid    in   1      operation request
//  req_ready    out  1      high only in IDLE
//  req_op       in   1      0 = multiply, 1 = divide
//  req_eA       in   8      operand A biased exponent (special check only)
//  req_eB       in   8      operand B biased exponent (special check only)
//  exp_en       out  1      exponent-logic register enable
//  exp_sel      out  1      exponent-logic select: 0 add-bias (mul), 1 sub+bias (div)
//  mant_load    out  1      load mantissa unit operands
//  mant_step    out  1      advance mantissa unit one step/iteration
//  iter_cnt     out  CNT_W  current mantissa step index
//  norm_en      out  1      normaliser enable
//  round_en     out  1      rounder enable
//  rsp_valid    out  1      result ready downstream
//  rsp_ready    in   1      downstream accepts result
//  rsp_special  out  1      result produced by special-case bypass
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  - Reset (arst=1 at an edge): state=IDLE, op_q=0, iter_cnt=0. All outputs 0 except req_ready=1.
//    Reset mid-operation aborts with no rsp_valid.
//  - FSM: IDLE -> EXP -> MANT -> NORM -> RND -> DONE -> IDLE.
//  - IDLE: on req_valid&&req_ready, latch req_op into op_q and go to EXP. req_* are ignored
//    in all other states.
//  - EXP (1 cycle): exp_en=1, mant_load=1, iter_cnt=0.
//  - MANT: mant_step=1 each cycle. iter_cnt counts 0..N-1, with N = op_q ? DIV_ITER : MUL_LAT.
//    Go to NORM on the cycle where iter_cnt==N-1. The counter clears when MANT is left.
//  - NORM (1 cycle): norm_en=1. RND (1 cycle): round_en=1.
//  - DONE: rsp_valid=1, held stable until rsp_ready. Then go to IDLE.
//    The next request is accepted no earlier than 1 cycle after the response handshake.
//  - exp_sel=op_q from EXP through DONE; 0 in IDLE.
//  - Enables are one-hot: at most one of exp_en/mant_step/norm_en/round_en per cycle.
//  - Latency, accept edge to first rsp_valid cycle: N+3 cycles (mul default 5, div default 29).
//  - rsp_ready high while not in DONE: no effect. req_valid high while busy: not accepted.
//    The requester must hold it.
// CONFIGURATION
//  FP_CTRL_SPECIAL_EN defined:
//    - At accept, if either exponent is 8'h00 or 8'hFF (zero/denormal/inf/NaN), skip to DONE.
//    - In that case rsp_valid rises 1 cycle after accept and rsp_special=1 while in DONE.
//    - exp_en/mant_*/norm_en/round_en stay 0.
//  Not defined: req_eA/req_eB are ignored, rsp_special is tied 0, and the full sequence
//  always runs.
// STRUCTURE
//  - Package fp_ctrl_pkg holds:
//      - typedef enum logic [2:0] ctrl_state_e {IDLE, EXP, MANT, NORM, RND, DONE}
//      - typedef enum logic op_e {OP_MUL=0, OP_DIV=1}
//      - localparams EXP_ZERO=8'h00, EXP_MAX=8'hFF
//  - Sub-module fp_iter_cnt: loadable up-counter with clear, enable and terminal-count output.
//    Instantiated once for the MANT phase.
// TESTING
//  1. arst=1 for 2 edges mid-idle -> all outputs 0, req_ready=1, busy=0.
//  2. mul: op=0, eA=130, eB=127, rsp_ready=1 -> exp_en 1 cycle with exp_sel=0; mant_step 2 cycles
//     (iter 0,1); rsp_valid on cycle 5.
//  3. div: op=1, eA=140, eB=120 -> exp_sel=1; mant_step 26 cycles with iter_cnt 0..25;
//     norm_en then round_en; rsp_valid on cycle 29.
//  4. Backpressure: rsp_ready=0 for 10 cycles after DONE, req_valid=1 throughout ->
//     rsp_valid held 10+ cycles, req_ready=0, no second accept until 1 cycle after rsp handshake.
//  5. Reset mid-divide when iter_cnt=10 -> next cycle IDLE, iter_cnt=0, no rsp_valid ever asserted.
//  6. With FP_CTRL_SPECIAL_EN: eA=8'h00, eB=127 -> rsp_valid 1 cycle after accept, rsp_special=1,
//     no exp_en/mant_step; eA=8'hFF likewise. Without the macro: same stimulus gives full 5-cycle
//     sequence with rsp_special=0.

Source files
------------

// File: rtl/fp_ctrl_pkg.sv
// Shared types and constants for the FP multiply/divide sequencer.
package fp_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXP,
    MANT,
    NORM,
    RND,
    DONE
  } ctrl_state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  localparam logic [7:0] EXP_ZERO = 8'h00;
  localparam logic [7:0] EXP_MAX  = 8'hFF;

  // Zero/denormal or inf/NaN exponent: result comes from the bypass path
  function automatic logic is_special_exp(input logic [7:0] e);
    return (e == EXP_ZERO) || (e == EXP_MAX);
  endfunction

endpackage

// File: rtl/fp_iter_cnt.sv
// Loadable up-counter with clear, enable and terminal-count compare.
// Paces the mantissa unit through its steps/iterations.
module fp_iter_cnt
  import fp_ctrl_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // Clear has priority over load, load over count
  always_ff @(posedge clk) begin
    if (arst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  // Terminal count: current index is the last step
  assign tc = (cnt == last);

endmodule

// File: rtl/fp_muldiv_ctrl.sv
// Sequencer for the FP multiply/divide datapath: exponent logic, mantissa
// unit, normaliser and rounder, with valid/ready request and response.
// Optional feature macro: FP_CTRL_SPECIAL_EN (special-exponent bypass).
//
//   state | meaning
//   IDLE  | waiting for a request, req_ready high
//   EXP   | exponent enable and mantissa operand load (1 cycle)
//   MANT  | mantissa steps, iter_cnt 0..N-1
//   NORM  | normaliser enable (1 cycle)
//   RND   | rounder enable (1 cycle)
//   DONE  | rsp_valid held until rsp_ready
module fp_muldiv_ctrl
  import fp_ctrl_pkg::*;
#(
  parameter  int MUL_LAT  = 2,
  parameter  int DIV_ITER = 26,
  localparam int CNT_W    = $clog2(((MUL_LAT > DIV_ITER) ? MUL_LAT : DIV_ITER) + 1)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [7:0]       req_eA,
  input  logic [7:0]       req_eB,
  output logic             exp_en,
  output logic             exp_sel,
  output logic             mant_load,
  output logic             mant_step,
  output logic [CNT_W-1:0] iter_cnt,
  output logic             norm_en,
  output logic             round_en,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_special,
  output logic             busy
);

  ctrl_state_e      state_q;
  op_e              op_q;
  logic             special_q;
  logic             spec_hit;
  logic             in_mant;
  logic             cnt_tc;
  logic [CNT_W-1:0] cnt_last;

  assign in_mant  = (state_q == MANT);
  assign cnt_last = (op_q == OP_DIV) ? CNT_W'(DIV_ITER - 1) : CNT_W'(MUL_LAT - 1);

`ifdef FP_CTRL_SPECIAL_EN
  // Either operand exponent all-zeros or all-ones bypasses the datapath
  assign spec_hit = is_special_exp(req_eA) || is_special_exp(req_eB);
`else
  // Exponents are not inspected; the full sequence always runs
  logic unused_eops;
  assign unused_eops = ^{req_eA, req_eB};
  assign spec_hit    = 1'b0;
`endif

  // Step counter: zeroed on EXP, counts through MANT, cleared on leaving MANT
  fp_iter_cnt #(
    .W(CNT_W)
  ) u_iter_cnt (
    .clk      (clk),
    .arst     (arst),
    .clr      (in_mant && cnt_tc),
    .load     (state_q == EXP),
    .load_val ({CNT_W{1'b0}}),
    .en       (in_mant && !cnt_tc),
    .last     (cnt_last),
    .cnt      (iter_cnt),
    .tc       (cnt_tc)
  );

  assign rsp_special = special_q;

  // Sequencer: next state and the registered enables that belong to it
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      special_q <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      exp_en    <= 1'b0;
      exp_sel   <= 1'b0;
      mant_load <= 1'b0;
      mant_step <= 1'b0;
      norm_en   <= 1'b0;
      round_en  <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= op_e'(req_op);
            exp_sel   <= req_op;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (spec_hit) begin
              state_q   <= DONE;
              special_q <= 1'b1;
              rsp_valid <= 1'b1;
            end else begin
              state_q   <= EXP;
              exp_en    <= 1'b1;
              mant_load <= 1'b1;
            end
          end
        end
        EXP: begin
          state_q   <= MANT;
          exp_en    <= 1'b0;
          mant_load <= 1'b0;
          mant_step <= 1'b1;
        end
        MANT: begin
          if (cnt_tc) begin
            state_q   <= NORM;
            mant_step <= 1'b0;
            norm_en   <= 1'b1;
          end
        end
        NORM: begin
          state_q  <= RND;
          norm_en  <= 1'b0;
          round_en <= 1'b1;
        end
        RND: begin
          state_q   <= DONE;
          round_en  <= 1'b0;
          rsp_valid <= 1'b1;
        end
        DONE: begin
          if (rsp_ready) begin
            state_q   <= IDLE;
            rsp_valid <= 1'b0;
            special_q <= 1'b0;
            exp_sel   <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          special_q <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          exp_en    <= 1'b0;
          exp_sel   <= 1'b0;
          mant_load <= 1'b0;
          mant_step <= 1'b0;
          norm_en   <= 1'b0;
          round_en  <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_muldiv_ctrl.sv
// Bench for fp_muldiv_ctrl: a timeline model (cycles since accept) checked
// every cycle, plus literal expectations for the directed scenarios.
// Honours FP_CTRL_SPECIAL_EN the same way as the design.
module tb_fp_muldiv_ctrl;

  localparam int MUL_LAT  = 2;
  localparam int DIV_ITER = 26;
  localparam int CNT_W    = 5;

  logic             clk = 1'b0;
  logic             arst;
  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [7:0]       req_eA;
  logic [7:0]       req_eB;
  logic             exp_en;
  logic             exp_sel;
  logic             mant_load;
  logic             mant_step;
  logic [CNT_W-1:0] iter_cnt;
  logic             norm_en;
  logic             round_en;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_special;
  logic             busy;

  fp_muldiv_ctrl #(
    .MUL_LAT (MUL_LAT),
    .DIV_ITER(DIV_ITER)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_eA     (req_eA),
    .req_eB     (req_eB),
    .exp_en     (exp_en),
    .exp_sel    (exp_sel),
    .mant_load  (mant_load),
    .mant_step  (mant_step),
    .iter_cnt   (iter_cnt),
    .norm_en    (norm_en),
    .round_en   (round_en),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_special(rsp_special),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit special_ops(input logic [7:0] a, input logic [7:0] b);
`ifdef FP_CTRL_SPECIAL_EN
    return (a == 8'h00) || (a == 8'hFF) || (b == 8'h00) || (b == 8'hFF);
`else
    return 1'b0;
`endif
  endfunction

  // Model: an operation is a timeline of ages (cycles after the accept edge).
  // age 0 exponent, ages 1..N mantissa step age-1, N+1 normalise, N+2 round,
  // N+3 onward response until taken. A special operation responds at age 0.
  bit m_busy;
  bit m_op;
  bit m_sp;
  int m_age;
  int m_n;
  int edge_cnt = 0;
  int acc_edge = -1;
  int hs_edge  = -1;
  int n_acc    = 0;
  int n_hs     = 0;

  always @(posedge clk) begin
    edge_cnt++;
    if (arst) begin
      m_busy = 1'b0;
      m_op   = 1'b0;
      m_sp   = 1'b0;
      m_age  = 0;
      m_n    = MUL_LAT;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy   = 1'b1;
        m_age    = 0;
        m_op     = req_op;
        m_n      = req_op ? DIV_ITER : MUL_LAT;
        m_sp     = special_ops(req_eA, req_eB);
        acc_edge = edge_cnt;
        n_acc++;
      end
    end else if (m_sp || m_age >= m_n + 3) begin
      if (rsp_ready) begin
        m_busy  = 1'b0;
        hs_edge = edge_cnt;
        n_hs++;
      end
    end else begin
      m_age++;
    end
  end

  // Scenario counters, observed at the falling edge
  int n_exp, n_step, n_norm, n_rnd, n_rv, n_sp, n_sel, max_iter, lat;

  bit e_done, e_run;
  int e_iter;

  // Compare DUT outputs against the model every cycle, and collect counts
  always @(negedge clk) begin
    if (chk_on) begin
      e_done = m_busy && (m_sp || m_age >= m_n + 3);
      e_run  = m_busy && !m_sp;
      e_iter = (e_run && m_age >= 1 && m_age <= m_n) ? m_age - 1 : 0;
      chk("req_ready",   32'(req_ready),   32'(!m_busy));
      chk("busy",        32'(busy),        32'(m_busy));
      chk("exp_en",      32'(exp_en),      32'(e_run && m_age == 0));
      chk("mant_load",   32'(mant_load),   32'(e_run && m_age == 0));
      chk("exp_sel",     32'(exp_sel),     32'(m_busy && m_op));
      chk("mant_step",   32'(mant_step),   32'(e_run && m_age >= 1 && m_age <= m_n));
      chk("iter_cnt",    32'(iter_cnt),    32'(e_iter));
      chk("norm_en",     32'(norm_en),     32'(e_run && m_age == m_n + 1));
      chk("round_en",    32'(round_en),    32'(e_run && m_age == m_n + 2));
      chk("rsp_valid",   32'(rsp_valid),   32'(e_done));
      chk("rsp_special", 32'(rsp_special), 32'(e_done && m_sp));
    end
    if (exp_en) n_exp++;
    if (mant_step) begin
      n_step++;
      if (int'(iter_cnt) > max_iter) max_iter = int'(iter_cnt);
    end
    if (norm_en) n_norm++;
    if (round_en) n_rnd++;
    if (exp_sel) n_sel++;
    if (rsp_special) n_sp++;
    if (rsp_valid) begin
      n_rv++;
      if (lat < 0) lat = edge_cnt - acc_edge;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    n_exp = 0; n_step = 0; n_norm = 0; n_rnd = 0; n_rv = 0;
    n_sp = 0; n_sel = 0; max_iter = 0; lat = -1;
  endtask

  task automatic wait_accept(input string name);
    int k = 0;
    int s = n_acc;
    while (n_acc == s && k < 20) begin
      tick();
      k++;
    end
    chk(name, 32'(n_acc != s), 32'd1);
  endtask

  task automatic wait_rsp(input string name);
    int k = 0;
    int s = n_hs;
    while (n_hs == s && k < 200) begin
      tick();
      k++;
    end
    chk(name, 32'(n_hs != s), 32'd1);
  endtask

  task automatic run_op(input logic op, input logic [7:0] a, input logic [7:0] b);
    clr_counts();
    req_valid = 1'b1;
    req_op    = op;
    req_eA    = a;
    req_eB    = b;
    wait_accept("accept_wait");
    req_valid = 1'b0;
    wait_rsp("rsp_wait");
    tick();
  endtask

  initial begin
    int k;
    arst = 1'b1; req_valid = 1'b0; req_op = 1'b0;
    req_eA = 8'd0; req_eB = 8'd0; rsp_ready = 1'b1;
    clr_counts();
    tick();
    chk_on = 1'b1;
    tick();
    arst = 1'b0;
    tick();
    tick();

    // 1: reset for two edges while idle
    arst = 1'b1;
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_iter_cnt",  32'(iter_cnt),  32'd0);
    chk("rst_exp_en",    32'(exp_en),    32'd0);
    arst = 1'b0;
    tick();

    // 2: multiply
    run_op(1'b0, 8'd130, 8'd127);
    chk("mul_exp_cycles",  32'(n_exp),    32'd1);
    chk("mul_step_cycles", 32'(n_step),   32'd2);
    chk("mul_max_iter",    32'(max_iter), 32'd1);
    chk("mul_norm",        32'(n_norm),   32'd1);
    chk("mul_round",       32'(n_rnd),    32'd1);
    chk("mul_latency",     32'(lat),      32'd5);
    chk("mul_sel_cycles",  32'(n_sel),    32'd0);
    chk("mul_rv_cycles",   32'(n_rv),     32'd1);

    // 3: divide
    run_op(1'b1, 8'd140, 8'd120);
    chk("div_step_cycles", 32'(n_step),   32'd26);
    chk("div_max_iter",    32'(max_iter), 32'd25);
    chk("div_norm",        32'(n_norm),   32'd1);
    chk("div_round",       32'(n_rnd),    32'd1);
    chk("div_latency",     32'(lat),      32'd29);
    chk("div_sel_cycles",  32'(n_sel),    32'd30);

    // 4: response backpressure with the next request already waiting
    clr_counts();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_op    = 1'b0;
    req_eA    = 8'd130;
    req_eB    = 8'd127;
    wait_accept("bp_accept_wait");
    k = 0;
    while (rsp_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    repeat (10) tick();
    rsp_ready = 1'b1;
    wait_accept("bp_second_accept");
    chk("bp_rv_cycles", 32'(n_rv), 32'd11);
    chk("bp_accept_gap", 32'(acc_edge - hs_edge), 32'd1);
    req_valid = 1'b0;
    wait_rsp("bp_second_rsp");
    tick();

    // 5: reset in the middle of a divide
    clr_counts();
    req_valid = 1'b1;
    req_op    = 1'b1;
    req_eA    = 8'd140;
    req_eB    = 8'd120;
    wait_accept("abort_accept_wait");
    req_valid = 1'b0;
    k = 0;
    while (iter_cnt !== CNT_W'(10) && k < 40) begin
      tick();
      k++;
    end
    chk("abort_iter_seen", 32'(iter_cnt), 32'd10);
    arst = 1'b1;
    tick();
    chk("abort_iter_cnt",  32'(iter_cnt),  32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_busy",      32'(busy),      32'd0);
    arst = 1'b0;
    repeat (35) tick();
    chk("abort_no_rsp", 32'(n_rv), 32'd0);

    // 6: special exponents
    run_op(1'b0, 8'h00, 8'd127);
`ifdef FP_CTRL_SPECIAL_EN
    chk("zero_latency",  32'(lat),    32'd0);
    chk("zero_special",  32'(n_sp),   32'd1);
    chk("zero_exp_en",   32'(n_exp),  32'd0);
    chk("zero_steps",    32'(n_step), 32'd0);
`else
    chk("zero_latency",  32'(lat),    32'd5);
    chk("zero_special",  32'(n_sp),   32'd0);
    chk("zero_exp_en",   32'(n_exp),  32'd1);
    chk("zero_steps",    32'(n_step), 32'd2);
`endif
    run_op(1'b0, 8'hFF, 8'd127);
`ifdef FP_CTRL_SPECIAL_EN
    chk("inf_latency",   32'(lat),    32'd0);
    chk("inf_special",   32'(n_sp),   32'd1);
    chk("inf_steps",     32'(n_step), 32'd0);
`else
    chk("inf_latency",   32'(lat),    32'd5);
    chk("inf_special",   32'(n_sp),   32'd0);
    chk("inf_steps",     32'(n_step), 32'd2);
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
